// File: rtl/sram_1rw_param_sim_if.sv
`default_nettype none
//============================================================================
// Module   : sram_1rw_param_sim_if
// Purpose  : Access bus of the parametrised 1RW SRAM model. It carries the
//            chip select, the write and output enables, the address, the
//            write mask and data, the read data and the status strobes.
// Revision : 1.0  initial release
//============================================================================
interface sram_1rw_param_sim_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int NLANES = 1
);
  logic              csb;
  logic              web;
  logic              oeb;
  logic [ADDR_W-1:0] a;
  logic [NLANES-1:0] wmb;
  logic [DATA_W-1:0] i;
  logic [DATA_W-1:0] o;
  logic              ovld;
  logic              busy;

  modport master (output csb, web, oeb, a, wmb, i, input o, ovld, busy);
  modport slave  (input csb, web, oeb, a, wmb, i, output o, ovld, busy);
endinterface
`default_nettype wire

// File: rtl/sram_1rw_param_sim.sv
`default_nettype none
//============================================================================
// Module   : sram_1rw_param_sim
// Purpose  : Behavioural single-port SRAM with these features:
//            - configurable depth and width
//            - active-low per-lane write mask
//            - read latency of 1 or 2 cycles, with a read-valid strobe
//            - optional zero-fill of the whole array after reset, with BUSY
// Revision : 1.0  initial release
//============================================================================
module sram_1rw_param_sim #(
  parameter int DEPTH        = 64,
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 8,
  parameter int LANE_W       = 8,
  parameter int READ_LAT     = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sram_1rw_param_sim_if.slave  bus
);
  localparam int NLANES = DATA_W / LANE_W;

  if ((READ_LAT != 1) && (READ_LAT != 2)) begin : g_bad_read_lat
    $fatal(1, "sram_1rw_param_sim: READ_LAT must be 1 or 2");
  end
  if ((DATA_W % LANE_W) != 0) begin : g_bad_lane_w
    $fatal(1, "sram_1rw_param_sim: DATA_W must be a multiple of LANE_W");
  end
  if ((2 ** ADDR_W) < DEPTH) begin : g_bad_addr_w
    $fatal(1, "sram_1rw_param_sim: ADDR_W too narrow for DEPTH");
  end

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // With zero-fill disabled the array is usable as soon as reset is released.
  localparam state_t RST_STATE = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;
  logic              last_clear;
  logic              clearing;
  logic              rd_en;
  logic              wr_en;
  logic              busy_flag;
  logic [DATA_W-1:0] rd_word;
  logic              stage_vld;
  logic [DATA_W-1:0] stage_data;
  logic              dout_vld;
  logic [DATA_W-1:0] dout;

  assign in_range   = (int'(bus.a) < DEPTH);
  assign last_clear = (ptr == ADDR_W'(DEPTH - 1));
  // Out-of-range reads still produce a strobe, but with all-zero data.
  assign rd_word    = in_range ? mem[bus.a] : '0;

  // State register: reset sends the FSM to CLEAR or READY depending on the fill option.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and access qualification: only READY honours bus accesses.
  always_comb begin
    state_nxt = state;
    clearing  = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    busy_flag = ~rst_n;
    case (state)
      ST_CLEAR: begin
        clearing  = 1'b1;
        busy_flag = 1'b1;
        if (last_clear) begin
          state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        rd_en = ~bus.csb & bus.web;
        wr_en = ~bus.csb & ~bus.web & in_range;
      end
      default: state_nxt = RST_STATE;
    endcase
  end

  // Datapath: zero-fill walk, masked writes and the read pipeline.
  // Reset leaves the array contents alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      stage_vld  <= 1'b0;
      stage_data <= '0;
      dout_vld   <= 1'b0;
      dout       <= '0;
    end else begin
      if (clearing) begin
        mem[ptr] <= '0;
        ptr      <= ptr + ADDR_W'(1);
      end
      if (wr_en) begin
        for (int k = 0; k < NLANES; k++) begin
          if (!bus.wmb[k]) begin
            mem[bus.a][k*LANE_W +: LANE_W] <= bus.i[k*LANE_W +: LANE_W];
          end
        end
      end
      if (READ_LAT == 2) begin
        stage_vld <= rd_en;
        if (rd_en) begin
          stage_data <= rd_word;
        end
        dout_vld <= stage_vld;
        if (stage_vld) begin
          dout <= stage_data;
        end
      end else begin
        dout_vld <= rd_en;
        if (rd_en) begin
          dout <= rd_word;
        end
      end
    end
  end

  assign bus.ovld = dout_vld;
  assign bus.busy = busy_flag;
  // The output enable only gates the pins; the held read data stays put.
  assign bus.o    = bus.oeb ? {DATA_W{1'bz}} : dout;

endmodule
`default_nettype wire

// File: tb/tb_sram_1rw_param_sim.sv
`default_nettype none
//============================================================================
// Module   : tb_sram_1rw_param_sim
// Purpose  : The same stimulus drives three SRAM configurations:
//              dut0  64x16, 1-cycle latency, zero-fill on
//              dut1  48x16, 2-cycle latency, zero-fill on
//              dut2  64x16, 1-cycle latency, zero-fill off
//            Each configuration is checked against a word-level memory
//            model on every cycle, plus hand-computed spot values.
// Revision : 1.0  initial release
//============================================================================
module tb_sram_1rw_param_sim;
  localparam int NDUT = 3;
  localparam int DEP [NDUT] = '{64, 48, 64};
  localparam int LAT [NDUT] = '{1, 2, 1};
  localparam int CLR [NDUT] = '{1, 1, 0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csb;
  logic        web;
  logic        oeb;
  logic [5:0]  a;
  logic [1:0]  wmb;
  logic [15:0] din;
  logic [15:0] o_mon    [NDUT];
  logic        ovld_mon [NDUT];
  logic        busy_mon [NDUT];
  int          vectors     = 0;
  int          miscompares = 0;

  // Model state: word contents, whether each word is defined, and the fill countdown.
  // It also keeps the delayed read result and the data last presented on O.
  logic [15:0] m_mem   [NDUT][64];
  logic        m_known [NDUT][64];
  int          fill_left [NDUT];
  logic        st_v [NDUT];
  logic [15:0] st_d [NDUT];
  logic        st_k [NDUT];
  logic        m_vld  [NDUT];
  logic [15:0] m_hold [NDUT];
  logic        m_hk   [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    sram_1rw_param_sim_if #(.ADDR_W(6), .DATA_W(16), .NLANES(2)) bus ();
    assign bus.csb     = csb;
    assign bus.web     = web;
    assign bus.oeb     = oeb;
    assign bus.a       = a;
    assign bus.wmb     = wmb;
    assign bus.i       = din;
    assign o_mon[g]    = bus.o;
    assign ovld_mon[g] = bus.ovld;
    assign busy_mon[g] = bus.busy;
    sram_1rw_param_sim #(
      .DEPTH(DEP[g]), .ADDR_W(6), .DATA_W(16), .LANE_W(8),
      .READ_LAT(LAT[g]), .CLEAR_ON_RST(CLR[g])
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  task automatic chk(input string nm, input int d, input logic [15:0] act, input logic [15:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %h, expected %h at %0t", nm, d, act, req, $time);
    end
  endtask

  // A released output may read as Z or 0, but never as a driven 1.
  function automatic logic no_ones(input logic [15:0] v);
    for (int b = 0; b < 16; b++) begin
      if (v[b] === 1'b1) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Advance the model by one rising clock edge using the inputs sampled at that edge.
  task automatic model_edge(input int d, input logic r, input logic c, input logic w,
                            input logic [5:0] ad, input logic [1:0] m, input logic [15:0] wd);
    logic        rv;
    logic        inr;
    logic        rk;
    logic [15:0] rdat;
    if (!r) begin
      fill_left[d] = (CLR[d] != 0) ? DEP[d] : 0;
      st_v[d]      = 1'b0;
      m_vld[d]     = 1'b0;
      m_hold[d]    = 16'h0;
      m_hk[d]      = 1'b1;
      return;
    end
    if (fill_left[d] > 0) begin
      fill_left[d]--;
      m_vld[d] = 1'b0;
      if (fill_left[d] == 0) begin
        for (int x = 0; x < 64; x++) begin
          m_mem[d][x]   = 16'h0;
          m_known[d][x] = 1'b1;
        end
      end
      return;
    end
    inr  = (int'(ad) < DEP[d]);
    rv   = !c && w;
    rdat = inr ? m_mem[d][ad] : 16'h0;
    rk   = inr ? m_known[d][ad] : 1'b1;
    if (!c && !w && inr) begin
      if (!m[0]) m_mem[d][ad][7:0]  = wd[7:0];
      if (!m[1]) m_mem[d][ad][15:8] = wd[15:8];
      if (m == 2'b00) m_known[d][ad] = 1'b1;
    end
    if (LAT[d] == 1) begin
      m_vld[d] = rv;
      if (rv) begin
        m_hold[d] = rdat;
        m_hk[d]   = rk;
      end
    end else begin
      m_vld[d] = st_v[d];
      if (st_v[d]) begin
        m_hold[d] = st_d[d];
        m_hk[d]   = st_k[d];
      end
      st_v[d] = rv;
      st_d[d] = rdat;
      st_k[d] = rk;
    end
  endtask

  // Model update on each rising edge; compare against every DUT on the falling edge.
  initial begin : compare
    logic        s_r;
    logic        s_c;
    logic        s_w;
    logic [5:0]  s_a;
    logic [1:0]  s_m;
    logic [15:0] s_d;
    for (int d = 0; d < NDUT; d++) begin
      fill_left[d] = 0;
      st_v[d]      = 1'b0;
      st_d[d]      = 16'h0;
      st_k[d]      = 1'b1;
      m_vld[d]     = 1'b0;
      m_hold[d]    = 16'h0;
      m_hk[d]      = 1'b1;
      for (int x = 0; x < 64; x++) begin
        m_mem[d][x]   = 16'h0;
        m_known[d][x] = 1'b0;
      end
    end
    forever begin
      @(posedge clk);
      s_r = rst_n; s_c = csb; s_w = web; s_a = a; s_m = wmb; s_d = din;
      for (int d = 0; d < NDUT; d++) model_edge(d, s_r, s_c, s_w, s_a, s_m, s_d);
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        chk("busy", d, 16'(busy_mon[d]), 16'(!rst_n || (fill_left[d] > 0)));
        chk("ovld", d, 16'(ovld_mon[d]), 16'(rst_n && m_vld[d]));
        if (oeb) chk("o_hiz", d, 16'(no_ones(o_mon[d])), 16'd1);
        else if (!rst_n) chk("o_rst", d, o_mon[d], 16'h0);
        else if (m_hk[d]) chk("o", d, o_mon[d], m_hold[d]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    csb = 1'b1;
    web = 1'b1;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wr(input logic [5:0] ad, input logic [1:0] m, input logic [15:0] d);
    csb = 1'b0; web = 1'b0; a = ad; wmb = m; din = d;
    tick();
    csb = 1'b1;
  endtask

  task automatic rd(input logic [5:0] ad);
    csb = 1'b0; web = 1'b1; a = ad; wmb = 2'b11;
    tick();
    csb = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst_n = 1'b0; csb = 1'b1; web = 1'b1; oeb = 1'b0; a = '0; wmb = 2'b11; din = '0;
    tick();
    tick();
    for (int d = 0; d < NDUT; d++) begin
      chk("lit_rst_busy", d, 16'(busy_mon[d]), 16'd1);
      chk("lit_rst_o", d, o_mon[d], 16'h0);
    end

    // Release: dut0/dut1 start filling and drop accesses, dut2 is ready at once.
    rst_n = 1'b1;
    wr(6'd3, 2'b00, 16'hDEAD);
    rd(6'd3);
    chk("lit_busy_no_ovld", 0, 16'(ovld_mon[0]), 16'd0);
    chk("lit_ready_rd", 2, o_mon[2], 16'hDEAD);
    idle(28);

    // Reset at fill cycle 30 restarts the whole fill.
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    wr(6'd10, 2'b00, 16'hFFFF);
    rd(6'd10);
    chk("lit_refill_drop", 0, 16'(ovld_mon[0]), 16'd0);
    idle(61);
    chk("lit_busy_63", 0, 16'(busy_mon[0]), 16'd1);
    idle(1);
    chk("lit_busy_64", 0, 16'(busy_mon[0]), 16'd0);
    chk("lit_busy_48", 1, 16'(busy_mon[1]), 16'd0);

    // Read back every address after the fill.
    for (int x = 0; x < 64; x++) rd(6'(x));
    idle(2);

    // Masked write: only the low lane takes the new data.
    wr(6'd5, 2'b00, 16'hFFFF);
    wr(6'd5, 2'b10, 16'h1234);
    wr(6'd5, 2'b11, 16'h0000);
    rd(6'd5);
    chk("lit_mask_o", 0, o_mon[0], 16'hFF34);
    chk("lit_mask_lat2", 1, 16'(ovld_mon[1]), 16'd0);
    idle(1);
    chk("lit_mask_o", 1, o_mon[1], 16'hFF34);
    chk("lit_mask_ovld", 1, 16'(ovld_mon[1]), 16'd1);
    idle(1);

    // Back-to-back reads: order preserved, latency 1 and 2.
    wr(6'd1, 2'b00, 16'h1111);
    wr(6'd2, 2'b00, 16'h2222);
    wr(6'd3, 2'b00, 16'h3333);
    rd(6'd1);
    chk("lit_lat1_first", 0, o_mon[0], 16'h1111);
    chk("lit_lat2_wait", 1, 16'(ovld_mon[1]), 16'd0);
    rd(6'd2);
    chk("lit_lat2_first", 1, o_mon[1], 16'h1111);
    rd(6'd3);
    chk("lit_lat1_third", 0, o_mon[0], 16'h3333);
    chk("lit_lat2_second", 1, o_mon[1], 16'h2222);
    idle(1);
    chk("lit_lat2_third", 1, o_mon[1], 16'h3333);
    chk("lit_lat1_done", 0, 16'(ovld_mon[0]), 16'd0);
    idle(2);

    // Write followed immediately by a read of the same word.
    wr(6'd9, 2'b00, 16'hABCD);
    rd(6'd9);
    chk("lit_wr_rd", 0, o_mon[0], 16'hABCD);

    // Out of range for dut1 only: write ignored, read gives zero with a strobe.
    wr(6'd50, 2'b00, 16'h5A5A);
    rd(6'd50);
    chk("lit_in_range", 0, o_mon[0], 16'h5A5A);
    idle(1);
    chk("lit_oor_o", 1, o_mon[1], 16'h0000);
    chk("lit_oor_ovld", 1, 16'(ovld_mon[1]), 16'd1);

    // Output disabled: pins released, strobe unaffected.
    oeb = 1'b1;
    rd(6'd9);
    chk("lit_oeb_ovld", 0, 16'(ovld_mon[0]), 16'd1);
    chk("lit_oeb_hiz", 0, 16'(no_ones(o_mon[0])), 16'd1);
    idle(1);
    chk("lit_oeb_ovld", 1, 16'(ovld_mon[1]), 16'd1);
    idle(1);
    oeb = 1'b0;
    #1;
    chk("lit_oeb_back", 1, o_mon[1], 16'hABCD);

    // Zero-fill disabled: contents survive a reset pulse and the array is ready at once.
    wr(6'd7, 2'b00, 16'h00A5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("lit_nofill_busy", 2, 16'(busy_mon[2]), 16'd0);
    chk("lit_fill_busy", 0, 16'(busy_mon[0]), 16'd1);
    rd(6'd7);
    chk("lit_nofill_keep", 2, o_mon[2], 16'h00A5);
    chk("lit_nofill_ovld", 2, 16'(ovld_mon[2]), 16'd1);
    chk("lit_fill_drop", 0, 16'(ovld_mon[0]), 16'd0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
